// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-position shift sequencer.
// Holds the FSM state encoding, the shift-direction encoding shared with
// n_bit_shifter, and the datapath width the sequencer is built for.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int SEQ_WIDTH = 8;

endpackage : shift_sequencer_pkg

// File: rtl/n_bit_shifter.sv
// One-position logical shifter, purely combinational.
// Ports:
//   d       input  N  operand
//   control input  1  0 = shift left, 1 = shift right
//   q       output N  d shifted by one position, zero-filled
module n_bit_shifter #(
    parameter int N = 8
) (
    input  logic [N-1:0] d,
    input  logic         control,
    output logic [N-1:0] q
);

    always_comb begin
        if (control) q = {1'b0, d[N-1:1]};
        else         q = {d[N-2:0], 1'b0};
    end

endmodule : n_bit_shifter

// File: rtl/shift_sequencer.sv
// Multi-position shift controller. Drives n_bit_shifter once per clock to
// perform a logical shift of 0..WIDTH positions left or right.
// Ports:
//   clk     input  1      rising-edge clock
//   reset   input  1      synchronous, active-high reset
//   start   input  1      request; accepted only while ready=1
//   dir     input  1      0 = left, 1 = right
//   amount  input  AMT_W  positions to shift, clamped to WIDTH
//   data_in input  WIDTH  operand, captured on accept
//   ready   output 1      high in IDLE and DONE
//   busy    output 1      high in SHIFT
//   done    output 1      one-cycle pulse in DONE
//   result  output WIDTH  shifted value, valid at done and held afterwards
//
// Handshake: a request is taken on any rising edge where ready=1 and
// start=1; dir, amount and data_in are sampled only on that edge. While
// busy=1 all request inputs are ignored. done pulses for exactly one cycle
// once the shift completes, and that DONE cycle is itself ready, so a start
// held high through it begins the next operation back-to-back.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Count must hold WIDTH itself, not just WIDTH-1.
    localparam int CNT_W = $clog2(WIDTH + 1);

    seq_state_t       state;
    logic [CNT_W-1:0] count;
    logic             dir_q;
    logic [CNT_W-1:0] clamped;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        if (int'(amount) > WIDTH) clamped = CNT_W'(WIDTH);
        else                      clamped = CNT_W'(amount);
    end

    n_bit_shifter #(
        .N(WIDTH)
    ) u_shifter (
        .d      (result),
        .control(dir_q),
        .q      (shifted)
    );

    // Status outputs are registered alongside the state so each one is a
    // direct flop of the state it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            result <= '0;
            count  <= '0;
            dir_q  <= DIR_LEFT;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        result <= data_in;
                        dir_q  <= dir;
                        count  <= clamped;
                        if (clamped != '0) begin
                            state <= ST_SHIFT;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            // Zero-length shift completes straight away.
                            state <= ST_DONE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    result <= shifted;
                    count  <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state <= ST_DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios followed by
// randomized operations, compared against an arithmetic reference model.
module tb_shift_sequencer;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] amount = 4'd0;
    logic [7:0] data_in = 8'd0;
    logic       ready, busy, done;
    logic [7:0] result;

    always #5 clk = ~clk;

    shift_sequencer #(
        .WIDTH(8),
        .AMT_W(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .dir    (dir),
        .amount (amount),
        .data_in(data_in),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         lat_q[$];
    logic [7:0] last_result = 8'd0;

    function automatic int clamp_n(input logic [3:0] a);
        return (int'(a) > 8) ? 8 : int'(a);
    endfunction

    // Logical shift by n positions, computed in one step.
    function automatic logic [7:0] model(input logic [7:0] d, input logic dr,
                                         input logic [3:0] a);
        int n;
        n = clamp_n(a);
        if (dr) return 8'(d >> n);
        else    return 8'(d << n);
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drives a request at the current (falling-edge) time; it is sampled
    // at the next rising edge.
    task automatic issue(input logic [7:0] d, input logic dr, input logic [3:0] a);
        check1("ready_at_issue", ready, 1'b1);
        start   = 1'b1;
        data_in = d;
        dir     = dr;
        amount  = a;
        exp_q.push_back(model(d, dr, a));
        lat_q.push_back(clamp_n(a));
    endtask

    // Follows one accepted operation cycle by cycle. In SHIFT cycles it may
    // drive junk requests that must be ignored; in the DONE cycle it either
    // drops start or chains the next request.
    task automatic complete(input bit chain, input logic [7:0] nd, input logic ndr,
                            input logic [3:0] na, input bit junk);
        int         n;
        logic [7:0] exp;
        n   = lat_q.pop_front();
        exp = exp_q.pop_front();
        for (int j = 1; j <= n + 1; j++) begin
            @(negedge clk);
            check1("busy", busy, j <= n);
            check1("done", done, j == n + 1);
            check1("ready", ready, j == n + 1);
            if (j <= n) begin
                if (junk) begin
                    start   = 1'b1;
                    data_in = 8'($urandom);
                    dir     = 1'($urandom);
                    amount  = 4'($urandom);
                end else begin
                    start = 1'b0;
                end
            end else begin
                check8("result_at_done", result, exp);
                last_result = exp;
                if (chain) issue(nd, ndr, na);
                else       start = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check1("idle_ready", ready, 1'b1);
            check1("idle_busy", busy, 1'b0);
            check1("idle_done", done, 1'b0);
            check8("idle_result_held", result, last_result);
        end
    endtask

    task automatic do_op(input logic [7:0] d, input logic dr, input logic [3:0] a,
                         input bit junk);
        idle_cycles(1);
        issue(d, dr, a);
        complete(1'b0, 8'd0, 1'b0, 4'd0, junk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] nd;
        logic       ndr;
        logic [3:0] na;
        bit         chain;
        bit         junk;

        // Reset asserted from time zero for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("reset_ready", ready, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check8("reset_result", result, 8'h00);
        reset = 1'b0;

        // Basic left and right shifts, with the held result checked.
        do_op(8'h96, 1'b0, 4'd3, 1'b0);
        idle_cycles(10);
        do_op(8'h96, 1'b1, 4'd3, 1'b0);
        // Zero amount.
        do_op(8'h5A, 1'b0, 4'd0, 1'b0);
        // Clamp and exact-width shifts.
        do_op(8'hFF, 1'b0, 4'd12, 1'b0);
        do_op(8'hFF, 1'b0, 4'd8, 1'b0);
        do_op(8'hC3, 1'b1, 4'd15, 1'b0);

        // Requests ignored while busy, then a back-to-back start in DONE.
        idle_cycles(1);
        issue(8'h01, 1'b0, 4'd5);
        complete(1'b1, 8'h80, 1'b1, 4'd7, 1'b1);
        complete(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);

        // Reset in the second SHIFT cycle aborts with no done pulse.
        idle_cycles(1);
        issue(8'h96, 1'b0, 4'd5);
        @(negedge clk);
        start = 1'b0;
        check1("abort_busy_c1", busy, 1'b1);
        @(negedge clk);
        check1("abort_busy_c2", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check8("abort_result", result, 8'h00);
        check1("abort_ready", ready, 1'b1);
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        exp_q.delete();
        lat_q.delete();
        last_result = 8'h00;
        idle_cycles(8);
        do_op(8'h96, 1'b0, 4'd2, 1'b0);

        // Randomized operations with random chaining, junk and idle gaps.
        idle_cycles(1);
        issue(8'($urandom), 1'($urandom), 4'($urandom));
        for (int k = 0; k < 40; k++) begin
            nd    = 8'($urandom);
            ndr   = 1'($urandom);
            na    = 4'($urandom_range(0, 15));
            chain = ($urandom_range(0, 3) == 0);
            junk  = 1'($urandom_range(0, 1));
            complete(chain, nd, ndr, na, junk);
            if (!chain) begin
                idle_cycles($urandom_range(1, 3));
                issue(nd, ndr, na);
            end
        end
        complete(1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        idle_cycles(2);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_shift_sequencer
